// File: rtl/jtag_gpr_access_pkg.sv
// Shared types and constants for the JTAG GPR access bridge:
// FSM state encoding, register bus widths and common fill constants.
package jtag_gpr_access_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG     = '0;
    localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic                  WRITE_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        JGA_IDLE = 3'd0,
        JGA_WR   = 3'd1,
        JGA_RD   = 3'd2,
        JGA_VFY  = 3'd3,
        JGA_RESP = 3'd4
    } jga_state_e;

endpackage

// File: rtl/jtag_gpr_access.sv
// Debug-side GPR bridge: retries JTAG accesses that collide with core writes.
// Define JTAG_GPR_VERIFY_EN to read back and compare every completed write.
module jtag_gpr_access
    import jtag_gpr_access_pkg::*;
#(
    parameter int MAX_RETRY = 15,
    parameter int RETRY_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [REG_ADDR_W-1:0] req_addr_i,
    input  logic [REG_DATA_W-1:0] req_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [REG_DATA_W-1:0] resp_data_o,
    output logic                  resp_err_o,
    input  logic                  core_we_i,
    input  logic [REG_ADDR_W-1:0] core_waddr_i,
    output logic                  jtag_we_o,
    output logic [REG_ADDR_W-1:0] jtag_addr_o,
    output logic [REG_DATA_W-1:0] jtag_data_o,
    input  logic [REG_DATA_W-1:0] jtag_data_i
);

    jga_state_e              state_q, state_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [REG_ADDR_W-1:0]   addr_q, addr_d;
    logic [REG_DATA_W-1:0]   data_q, data_d;
    logic [REG_DATA_W-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    collide, stale, retry_out;

    // The register file drops a JTAG write on any core write; a read is stale only on a hit.
    assign collide   = core_we_i && (core_waddr_i != ZERO_REG);
    assign stale     = core_we_i && (core_waddr_i == addr_q);
    assign retry_out = (retry_q == RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= JGA_IDLE;
            retry_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        jtag_we_o    = 1'b0;
        jtag_addr_o  = ZERO_REG;
        jtag_data_o  = ZERO_WORD;

        case (state_q)
            JGA_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    data_d  = req_data_i;
                    retry_d = '0;
                    if (req_addr_i == ZERO_REG) begin
                        state_d = JGA_RESP;
                        err_d   = 1'b0;
                        rdata_d = req_write_i ? req_data_i : ZERO_WORD;
                    end else begin
                        state_d = req_write_i ? JGA_WR : JGA_RD;
                    end
                end
            end

            JGA_WR: begin
                jtag_we_o   = WRITE_ENABLE;
                jtag_addr_o = addr_q;
                jtag_data_o = data_q;
                if (collide) begin
                    if (retry_out) begin
                        state_d = JGA_RESP;
                        err_d   = 1'b1;
                        rdata_d = data_q;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end else begin
`ifdef JTAG_GPR_VERIFY_EN
                    state_d = JGA_VFY;
                    retry_d = '0;
`else
                    state_d = JGA_RESP;
                    err_d   = 1'b0;
                    rdata_d = data_q;
`endif
                end
            end

            JGA_RD: begin
                jtag_addr_o = addr_q;
                if (stale) begin
                    if (retry_out) begin
                        state_d = JGA_RESP;
                        err_d   = 1'b1;
                        rdata_d = ZERO_WORD;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end else begin
                    state_d = JGA_RESP;
                    err_d   = 1'b0;
                    rdata_d = jtag_data_i;
                end
            end

`ifdef JTAG_GPR_VERIFY_EN
            JGA_VFY: begin
                jtag_addr_o = addr_q;
                rdata_d     = data_q;
                if (stale) begin
                    if (retry_out) begin
                        state_d = JGA_RESP;
                        err_d   = 1'b1;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end else begin
                    state_d = JGA_RESP;
                    err_d   = (jtag_data_i != data_q);
                end
            end
`endif

            JGA_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = JGA_IDLE;
                end
            end

            default: state_d = JGA_IDLE;
        endcase
    end

    assign resp_data_o = rdata_q;
    assign resp_err_o  = err_q;

endmodule
